// File: rtl/sensor_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_display_pkg
//  Purpose  : Shared types and constants for sensor_display_ctrl: direction
//             codes, 7-segment glyphs (active-low, bit6=g .. bit0=a) and the
//             hex font / direction glyph lookup helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package sensor_display_pkg;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'd0,
        DIR_FWD   = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_REV   = 3'd4,
        DIR_STOP  = 3'd5
    } dir_e;

    localparam logic [6:0] C_SEG_BLANK  = 7'h7F;
    localparam logic [6:0] C_GLYPH_F    = 7'b0001110;
    localparam logic [6:0] C_GLYPH_R    = 7'b0101111;
    localparam logic [6:0] C_GLYPH_L    = 7'b1000111;
    localparam logic [6:0] C_GLYPH_B    = 7'b0000011;
    localparam logic [6:0] C_GLYPH_DASH = 7'b0111111;

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] dir_glyph(input dir_e d);
        logic [6:0] seg;
        case (d)
            DIR_FWD:   seg = C_GLYPH_F;
            DIR_RIGHT: seg = C_GLYPH_R;
            DIR_LEFT:  seg = C_GLYPH_L;
            DIR_REV:   seg = C_GLYPH_B;
            DIR_STOP:  seg = C_GLYPH_DASH;
            default:   seg = C_SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_display_ctrl_sen_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sen_debounce
//  Purpose  : 2-flop synchroniser followed by a stability counter. The
//             debounced level follows the synchronised input only after it
//             has differed from the current level for DEB_CYC consecutive
//             cycles; any return to the current level restarts the count.
//  Ports    : clk, rst_n (async, active-low)
//             d_i  - raw asynchronous input
//             q_o  - debounced level (reset 0)
//  Revision : 1.0 - initial release
// ============================================================================
module sen_debounce #(
    parameter int DEB_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(DEB_CYC - 1);

    logic          meta_q;
    logic          sync_q;
    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            lvl_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            lvl_q  <= lvl_d;
            cnt_q  <= cnt_d;
        end
    end

    // Counter only runs while the synchronised value disagrees with the
    // accepted level; the last count accepts the new level.
    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        if (sync_q == lvl_q) begin
            cnt_d = '0;
        end else if (cnt_q == C_CNT_LAST) begin
            lvl_d = sync_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign q_o = lvl_q;

endmodule
`default_nettype wire

// File: rtl/sensor_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_display_ctrl
//  Purpose  : Debounces four obstacle sensors, runs the direction FSM with a
//             minimum dwell time, counts avoidance commits and drives an
//             N_DIG-digit multiplexed 7-segment display (digit 0 = direction
//             glyph, digits 1.. = hex counter).
//  Ports    : clk, rst_n (async, active-low)
//             sen_f_i/sen_d_i/sen_e_i/sen_a_i - front/right/left/rear sensors
//             control_i - system enable
//             dir_o     - committed direction code
//             dir_chg_o - one-cycle pulse on each direction change
//             seg_n_o   - segments g..a, active-low
//             an_n_o    - digit enables, active-low
//  Config   : SEGDISP_LZB_EN - leading-zero blanking of counter digits
//  Revision : 1.0 - initial release
// ============================================================================
module sensor_display_ctrl
    import sensor_display_pkg::*;
#(
    parameter int N_DIG    = 4,
    parameter int DEB_CYC  = 1000,
    parameter int HOLD_CYC = 5000,
    parameter int SCAN_DIV = 2500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sen_f_i,
    input  logic             sen_d_i,
    input  logic             sen_e_i,
    input  logic             sen_a_i,
    input  logic             control_i,
    output logic [2:0]       dir_o,
    output logic             dir_chg_o,
    output logic [6:0]       seg_n_o,
    output logic [N_DIG-1:0] an_n_o
);

    localparam int CW = 4 * (N_DIG - 1);
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(N_DIG);
    localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [DW-1:0] C_DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] C_IDX_LAST  = IW'(N_DIG - 1);

    // ---------------- input conditioning ----------------
    logic [3:0] w_sen_raw;
    logic [3:0] w_sen_deb;   // [0]=f [1]=d [2]=e [3]=a
    logic       ctrl_meta_q, ctrl_sync_q;

    assign w_sen_raw = {sen_a_i, sen_e_i, sen_d_i, sen_f_i};

    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
        sen_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (w_sen_raw[gi]),
            .q_o   (w_sen_deb[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_meta_q <= 1'b0;
            ctrl_sync_q <= 1'b0;
        end else begin
            ctrl_meta_q <= control_i;
            ctrl_sync_q <= ctrl_meta_q;
        end
    end

    // ---------------- direction FSM ----------------
    dir_e          state_q, state_d;
    dir_e          w_decision;
    logic [HW-1:0] hold_q, hold_d;
    logic          w_hold_done;
    logic          w_commit;
    logic          w_count_en;
    logic          dir_chg_q;
    logic [CW-1:0] cnt_q, cnt_d;

    assign w_hold_done = (hold_q >= C_HOLD_LAST);

    always_comb begin
        w_decision = DIR_STOP;
        if (!w_sen_deb[0])      w_decision = DIR_FWD;
        else if (!w_sen_deb[1]) w_decision = DIR_RIGHT;
        else if (!w_sen_deb[2]) w_decision = DIR_LEFT;
        else if (!w_sen_deb[3]) w_decision = DIR_REV;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= DIR_IDLE;
        else        state_q <= state_d;
    end

    // Disable wins over the dwell timer; otherwise a non-IDLE state only
    // re-evaluates once the timer has reached its last count.
    always_comb begin
        state_d = state_q;
        if (!ctrl_sync_q) begin
            state_d = DIR_IDLE;
        end else if (state_q == DIR_IDLE) begin
            state_d = w_decision;
        end else if (w_hold_done && (w_decision != state_q)) begin
            state_d = w_decision;
        end
    end

    always_comb begin
        w_commit   = (state_d != state_q);
        w_count_en = w_commit && (state_d inside {DIR_RIGHT, DIR_LEFT, DIR_REV, DIR_STOP});
        hold_d     = hold_q;
        if (w_commit || (state_q == DIR_IDLE)) hold_d = '0;
        else if (!w_hold_done)                 hold_d = hold_q + HW'(1);
        cnt_d = w_count_en ? (cnt_q + CW'(1)) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            cnt_q     <= '0;
            dir_chg_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            dir_chg_q <= w_commit;
        end
    end

    assign dir_o     = state_q;
    assign dir_chg_o = dir_chg_q;

    // ---------------- display scan ----------------
    logic [DW-1:0]    div_q, div_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    w_shift;
    logic [6:0]       seg_n_q, seg_n_d;
    logic [N_DIG-1:0] an_n_q, an_n_d;

    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (state_q == DIR_IDLE) begin
            div_d = '0;
            idx_d = '0;
        end else if (div_q == C_DIV_LAST) begin
            div_d = '0;
            idx_d = (idx_q == C_IDX_LAST) ? '0 : (idx_q + IW'(1));
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // w_shift holds nibble idx-1 in its low bits and every higher nibble
    // above it, so a zero value means "this and all higher digits are 0".
    always_comb begin
        w_shift = cnt_q >> {idx_q - IW'(1), 2'b00};
        seg_n_d = C_SEG_BLANK;
        an_n_d  = '1;
        if (state_q != DIR_IDLE) begin
            an_n_d = ~(N_DIG'(1) << idx_q);
            if (idx_q == '0) begin
                seg_n_d = dir_glyph(state_q);
            end else begin
                seg_n_d = hex_font(w_shift[3:0]);
`ifdef SEGDISP_LZB_EN
                if ((idx_q > IW'(1)) && (w_shift == '0)) seg_n_d = C_SEG_BLANK;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            idx_q   <= '0;
            seg_n_q <= C_SEG_BLANK;
            an_n_q  <= '1;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            seg_n_q <= seg_n_d;
            an_n_q  <= an_n_d;
        end
    end

    assign seg_n_o = seg_n_q;
    assign an_n_o  = an_n_q;

endmodule
`default_nettype wire
